ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised execute unit for the RV32IM core pipeline, sitting between the decode and memory stages in place of the single-cycle ALU. It performs all integer ALU operations in one cycle and M-extension multiply, divide and remainder iteratively over XLEN cycles. It also supplies a registered result and forwarding data to decode, and a stall request to pipeline control while an iterative operation is in flight.

## Interface
- XLEN, 32, datapath width; power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous abort of any accepted or in-flight op.
- in_valid  in  1  op present on inputs.
- in_ready  out  1  unit can accept this cycle.
- op  in  5  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18–31 reserved.
- src1, src2  in  XLEN  operands; immediates are already merged into src2 by decode.
- wd_i  in  5  destination register.
- wreg_i  in  1  write-enable.
- out_valid  out  1  single-cycle result pulse.
- out_data  out  XLEN  result.
- out_wd  out  5  destination register, captured at accept.
- out_wreg  out  1  write-enable, captured at accept; qualified by out_valid.
- fwd_wreg, fwd_wd, fwd_data  out  1/5/XLEN  forwarding to decode; equal to out_wreg&out_valid, out_wd, out_data.
- stall_req  out  1  high while the state is MUL or DIV.

## Operation
- Accept occurs when in_valid && in_ready && !flush.
- in_ready = (state == IDLE). There is no output backpressure.
- States:
  - IDLE: on accept of an ALU op, a reserved op, or a divide special case, register the result and go to DONE. On accept of MUL* go to MUL. On accept of DIV*/REM* (non-special) go to DIV.
  - MUL: radix-2 shift-add, one operand bit per cycle, 2·XLEN-bit accumulator. Iteration counter runs 0..XLEN-1, then go to DONE.
  - DIV: restoring divide on operand magnitudes, one quotient bit per cycle, counter 0..XLEN-1. Apply the sign fix-up in the last cycle, then go to DONE.
  - DONE: out_valid=1 for exactly one cycle, then go to IDLE. in_ready=0 in DONE.
- ALU rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare; SLTU is unsigned. Result is 0 or 1, zero-extended.
  - Shifts use src2[SHW-1:0] only. SRA replicates src1[XLEN-1].
  - Reserved ops give result 0 with out_wreg forced 0.
- Multiply rules:
  - MUL returns product[XLEN-1:0].
  - MULH returns product[2XLEN-1:XLEN] with signed×signed operands.
  - MULHSU returns the same field with signed src1 × unsigned src2.
  - MULHU returns the same field with unsigned×unsigned operands.
- Divide special cases are handled in a single cycle, with no DIV state:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give src1.
  - Signed overflow (src1 = 100…0, src2 = all-ones) for DIV/REM: DIV gives src1; REM gives 0.
- Signed divide sign rules: the quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
- flush, in any state: next state is IDLE, no out_valid pulse, counters cleared. flush on the same cycle as in_valid prevents the accept.
- rst has the same effect as flush, plus output clearing.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_wd 0, out_wreg 0, stall_req 0, all fwd_* 0.
- ALU, reserved and divide special-case ops: accept in cycle N, out_valid in N+1. Back-to-back accept in N+2 (throughput is 1 op per 2 cycles).
- MUL*/DIV*/REM*: accept in N. Iterations run in cycles N+1 .. N+XLEN. out_valid in N+XLEN+1.
- stall_req is high in cycles N+1 .. N+XLEN and low in DONE.
- out_data, out_wd and out_wreg hold their values after the out_valid pulse until the next DONE.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 -> out_valid exactly 1 cycle after accept, out_data 0x80000000. SRA 0x80000000 by src2=0x21 -> 0xC0000000 (shift amount 1).
- SLT −1 vs 1 -> 1; SLTU 0xFFFFFFFF vs 1 -> 0. out_wd equals the wd_i presented at accept.
- MULH 0x80000000 × 0x80000000 -> 0x40000000 at accept+33, stall_req high for exactly 32 cycles. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MUL −3 × 7 -> 0xFFFFFFEB.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2. Each completes at accept+33.
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / −1 -> 0x80000000. Each at accept+1 with no stall_req.
- Start DIVU, then assert flush at accept+10 -> no out_valid pulse, in_ready 1 the next cycle, and a following ADD completes normally. Repeat with rst -> all outputs read their reset values.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute unit for the RV32IM pipeline. Integer ALU ops finish in
// one cycle; M-extension multiply/divide/remainder iterate one bit per cycle
// for XLEN cycles. Results are registered and mirrored onto the forwarding
// outputs for decode.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             abort any accepted or in-flight op (blocks a same-cycle accept)
//   in_valid/in_ready input handshake; op/src1/src2/wd_i/wreg_i are the op fields
//   out_valid         one-cycle result pulse; out_data/out_wd/out_wreg hold afterwards
//   fwd_wreg/wd/data  forwarding copy of the result (fwd_wreg qualified by out_valid)
//   stall_req         high while a multiply or divide is iterating
//   dbg_state_o       current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
//
// Handshake: an op is taken on a rising edge where in_valid && in_ready &&
// !flush. in_ready is high only in IDLE. out_valid is a single-cycle pulse
// with no backpressure; the consumer must take it in that cycle.
module ex_muldiv #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_wd,
  output logic            out_wreg,
  output logic            fwd_wreg,
  output logic [4:0]      fwd_wd,
  output logic [XLEN-1:0] fwd_data,
  output logic            stall_req,
  output logic [1:0]      dbg_state_o
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // MUL: product; DIV: {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   opnd_q, opnd_d;   // MUL: shifting multiplicand; DIV: divisor in low half
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d;     // negate product / quotient at the end
  logic                rneg_q, rneg_d;   // negate remainder at the end
  logic [4:0]          pend_wd_q, pend_wd_d;
  logic                pend_wreg_q, pend_wreg_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic [4:0]          wd_q, wd_d;
  logic                wreg_q, wreg_d;

  logic accept;
  assign accept = in_valid && in_ready && !flush;

  // ---------------- decode and single-cycle results ----------------
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, spec_res, a_mag, b_mag;
  logic            is_mul, is_div, is_resv, div_signed, div_zero, div_ovf, div_special;
  logic            a_neg, b_neg, a_signed, b_signed;

  assign shamt       = src2[SHW-1:0];
  assign is_mul      = (op >= OP_MUL) && (op <= OP_MULHU);
  assign is_div      = (op >= OP_DIV) && (op <= OP_REMU);
  assign is_resv     = (op > OP_REMU);
  assign div_signed  = (op == OP_DIV) || (op == OP_REM);
  assign div_zero    = (src2 == '0);
  assign div_ovf     = div_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  assign div_special = is_div && (div_zero || div_ovf);
  assign a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || div_signed;
  assign b_signed    = (op == OP_MULH) || div_signed;
  assign a_neg       = a_signed && src1[XLEN-1];
  assign b_neg       = b_signed && src2[XLEN-1];
  // Iterations run on magnitudes; signs are re-applied in the last cycle.
  assign a_mag       = a_neg ? -src1 : src1;
  assign b_mag       = b_neg ? -src2 : src2;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_SLL:  alu_res = src1 << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = $signed(src1) >>> shamt;
      OP_OR:   alu_res = src1 | src2;
      OP_AND:  alu_res = src1 & src2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    spec_res = '0;
    if (div_zero)
      spec_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src1;
    else
      spec_res = (op == OP_DIV) ? src1 : '0;
  end

  // ---------------- iterative datapath steps ----------------
  logic [2*XLEN-1:0] mul_acc, mul_prod, div_acc;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   mul_res, div_res, div_q, div_r;
  logic              cnt_last;

  assign cnt_last = (cnt_q == SHW'(XLEN-1));
  assign mul_acc  = acc_q + (mplier_q[0] ? opnd_q : '0);
  assign mul_prod = neg_q ? -mul_acc : mul_acc;
  assign mul_res  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Restoring step: shift {rem, dividend} left one bit and try subtracting.
  assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign diff    = rem_sh - {1'b0, opnd_q[XLEN-1:0]};
  assign div_acc = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
  assign div_q   = div_acc[XLEN-1:0];
  assign div_r   = div_acc[2*XLEN-1:XLEN];
  assign div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? (neg_q ? -div_q : div_q)
                                                           : (rneg_q ? -div_r : div_r);

  // ---------------- FSM next state and register updates ----------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    mplier_d    = mplier_q;
    op_d        = op_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    pend_wd_d   = pend_wd_q;
    pend_wreg_d = pend_wreg_q;
    data_d      = data_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d        = op;
          pend_wd_d   = wd_i;
          pend_wreg_d = wreg_i;
          neg_d       = a_neg ^ b_neg;
          rneg_d      = a_neg;
          cnt_d       = '0;
          if (is_mul) begin
            state_d  = S_MUL;
            acc_d    = '0;
            opnd_d   = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
          end else if (is_div && !div_special) begin
            state_d = S_DIV;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opnd_d  = {{XLEN{1'b0}}, b_mag};
          end else begin
            state_d = S_DONE;
            data_d  = div_special ? spec_res : alu_res;
            wd_d    = wd_i;
            wreg_d  = wreg_i && !is_resv;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_acc;
        opnd_d   = opnd_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          data_d  = mul_res;
          wd_d    = pend_wd_q;
          wreg_d  = pend_wreg_q;
        end
      end
      S_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          data_d  = div_res;
          wd_d    = pend_wd_q;
          wreg_d  = pend_wreg_q;
        end
      end
      default: state_d = S_IDLE;  // S_DONE
    endcase
    // Abort keeps the previously published result untouched.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      data_d  = data_q;
      wd_d    = wd_q;
      wreg_d  = wreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      mplier_q    <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      pend_wd_q   <= '0;
      pend_wreg_q <= 1'b0;
      data_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      mplier_q    <= mplier_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      pend_wd_q   <= pend_wd_d;
      pend_wreg_q <= pend_wreg_d;
      data_q      <= data_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign stall_req   = (state_q == S_MUL) || (state_q == S_DIV);
  assign out_data    = data_q;
  assign out_wd      = wd_q;
  assign out_wreg    = wreg_q;
  assign fwd_wreg    = wreg_q && out_valid;
  assign fwd_wd      = wd_q;
  assign fwd_data    = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [4:0]      t_op = '0;
  logic [31:0]     t_src1 = '0, t_src2 = '0;
  logic [4:0]      t_wd = '0;
  logic            t_wreg = 1'b0;
  logic            out_valid, out_wreg, fwd_wreg, stall_req;
  logic [31:0]     out_data, fwd_data;
  logic [4:0]      out_wd, fwd_wd;
  logic [1:0]      dbg_state;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(t_op), .src1(t_src1), .src2(t_src2), .wd_i(t_wd), .wreg_i(t_wreg),
    .out_valid(out_valid), .out_data(out_data), .out_wd(out_wd), .out_wreg(out_wreg),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_data(fwd_data),
    .stall_req(stall_req), .dbg_state_o(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // scoreboard of expected results, one entry per accepted op
  logic [XLEN-1:0] exp_q[$];
  logic [31:0] last_data = '0;
  logic [4:0]  last_wd = '0;
  logic        last_wreg = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic wr_ok, output int lat);
    logic [63:0] p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    wr_ok = 1'b1;
    lat = 1;
    p = '0;
    d = '0;
    case (op)
      5'd0:  d = a + b;
      5'd1:  d = a - b;
      5'd2:  d = a << b[4:0];
      5'd3:  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  d = (a < b) ? 32'd1 : 32'd0;
      5'd5:  d = a ^ b;
      5'd6:  d = a >> b[4:0];
      5'd7:  d = $signed(a) >>> b[4:0];
      5'd8:  d = a | b;
      5'd9:  d = a & b;
      5'd10: begin p = {32'b0, a} * {32'b0, b}; d = p[31:0]; lat = XLEN + 1; end
      5'd11: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); d = p[63:32]; lat = XLEN + 1; end
      5'd12: begin p = {{32{a[31]}}, a} * {32'b0, b}; d = p[63:32]; lat = XLEN + 1; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; d = p[63:32]; lat = XLEN + 1; end
      5'd14: begin
        if (b == 0) d = '1;
        else if (ovf) d = a;
        else begin d = $signed(a) / $signed(b); lat = XLEN + 1; end
      end
      5'd15: begin
        if (b == 0) d = '1;
        else begin d = a / b; lat = XLEN + 1; end
      end
      5'd16: begin
        if (b == 0) d = a;
        else if (ovf) d = '0;
        else begin d = $signed(a) % $signed(b); lat = XLEN + 1; end
      end
      5'd17: begin
        if (b == 0) d = a;
        else begin d = a % b; lat = XLEN + 1; end
      end
      default: begin d = '0; wr_ok = 1'b0; end
    endcase
  endfunction

  // ---------------- driver: one op, fully checked ----------------
  // Entered and left on a falling edge; leaving right after the pulse lets
  // the next call exercise back-to-back acceptance.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] exp_d,
                        input logic exp_wreg, input int exp_lat, input string name);
    int lat, stalls;
    bit got;
    check({name, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; t_op = op; t_src1 = a; t_src2 = b; t_wd = wd; t_wreg = wreg;
    exp_q.push_back(exp_d);
    @(negedge clk);
    in_valid = 1'b0;
    t_op = 5'($urandom); t_src1 = $urandom; t_src2 = $urandom; t_wd = ~wd; t_wreg = ~wreg;
    lat = 1; stalls = 0; got = 0;
    while (lat <= 100) begin
      if (out_valid) begin got = 1; break; end
      if (stall_req) stalls++;
      @(negedge clk);
      lat++;
    end
    check({name, " completed"}, got, 1);
    if (got) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check({name, " latency"}, lat, exp_lat);
      check({name, " stall_cycles"}, stalls, (exp_lat > 1) ? XLEN : 0);
      check({name, " stall_in_done"}, stall_req, 0);
      check({name, " ready_in_done"}, in_ready, 0);
      check({name, " out_data"}, out_data, e);
      check({name, " out_wd"}, out_wd, wd);
      check({name, " out_wreg"}, out_wreg, exp_wreg);
      check({name, " fwd_wreg"}, fwd_wreg, exp_wreg);
      check({name, " fwd_wd"}, fwd_wd, wd);
      check({name, " fwd_data"}, fwd_data, e);
      @(negedge clk);
      check({name, " single_pulse"}, out_valid, 0);
      check({name, " data_hold"}, out_data, e);
      last_data = e; last_wd = wd; last_wreg = exp_wreg;
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " in_ready"}, in_ready, 1);
    check({name, " out_valid"}, out_valid, 0);
    check({name, " out_data"}, out_data, 0);
    check({name, " out_wd"}, out_wd, 0);
    check({name, " out_wreg"}, out_wreg, 0);
    check({name, " stall_req"}, stall_req, 0);
    check({name, " fwd_wreg"}, fwd_wreg, 0);
    check({name, " fwd_wd"}, fwd_wd, 0);
    check({name, " fwd_data"}, fwd_data, 0);
  endtask

  // watch n cycles and count any out_valid pulses
  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_wreg;
    int          lat;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_d, input logic exp_wreg, input int lat, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_d = exp_d; v.exp_wreg = exp_wreg; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] md;
    logic wok;
    int mlat;

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    add(5'd0,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1, 1,  "add_wrap");
    add(5'd7,  32'h8000_0000, 32'h21,         32'hC000_0000, 1, 1,  "sra_amt1");
    add(5'd3,  32'hFFFF_FFFF, 32'h1,          32'h1,         1, 1,  "slt_neg");
    add(5'd4,  32'hFFFF_FFFF, 32'h1,          32'h0,         1, 1,  "sltu_big");
    add(5'd1,  32'h0,         32'h1,          32'hFFFF_FFFF, 1, 1,  "sub_wrap");
    add(5'd2,  32'h1,         32'h3F,         32'h8000_0000, 1, 1,  "sll_31");
    add(5'd6,  32'h8000_0000, 32'h3F,         32'h1,         1, 1,  "srl_31");
    add(5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0, 1, 1,  "xor");
    add(5'd8,  32'h0000_F000, 32'h0000_0F00,  32'h0000_FF00, 1, 1,  "or");
    add(5'd9,  32'hFFFF_0000, 32'h1234_5678,  32'h1234_0000, 1, 1,  "and");
    add(5'd20, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0,         0, 1,  "reserved");
    add(5'd11, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 1, 33, "mulh_min");
    add(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 1, 33, "mulhu_max");
    add(5'd10, 32'hFFFF_FFFD, 32'h7,          32'hFFFF_FFEB, 1, 33, "mul_neg");
    add(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 33, "mulhsu");
    add(5'd14, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD, 1, 33, "div_neg");
    add(5'd16, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 1, 33, "rem_neg");
    add(5'd14, 32'h7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 1, 33, "div_negdiv");
    add(5'd16, 32'h7,         32'hFFFF_FFFE,  32'h1,         1, 33, "rem_negdiv");
    add(5'd15, 32'd100,       32'd7,          32'd14,        1, 33, "divu");
    add(5'd17, 32'd100,       32'd7,          32'd2,         1, 33, "remu");
    add(5'd14, 32'd5,         32'd0,          32'hFFFF_FFFF, 1, 1,  "div_by0");
    add(5'd16, 32'd5,         32'd0,          32'd5,         1, 1,  "rem_by0");
    add(5'd15, 32'd5,         32'd0,          32'hFFFF_FFFF, 1, 1,  "divu_by0");
    add(5'd17, 32'd5,         32'd0,          32'd5,         1, 1,  "remu_by0");
    add(5'd14, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1, 1,  "div_ovf");
    add(5'd16, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         1, 1,  "rem_ovf");

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1,
             vecs[i].exp_d, vecs[i].exp_wreg, vecs[i].lat, vecs[i].name);

    // wreg_i low must propagate unchanged
    run_op(5'd0, 32'd3, 32'd4, 5'd9, 1'b0, 32'd7, 1'b0, 1, "add_nowreg");

    // flush mid-divide: no pulse, ready next cycle, old result held
    in_valid = 1'b1; t_op = 5'd15; t_src1 = 32'd1000; t_src2 = 32'd3; t_wd = 5'd17; t_wreg = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", in_ready, 1);
    check("flush stall_req", stall_req, 0);
    count_pulses(40, pulses);
    check("flush no_pulse", pulses, 0);
    check("flush data_hold", out_data, last_data);
    check("flush wd_hold", out_wd, last_wd);
    run_op(5'd0, 32'd10, 32'd20, 5'd3, 1'b1, 32'd30, 1'b1, 1, "add_after_flush");

    // flush together with in_valid blocks the accept
    in_valid = 1'b1; flush = 1'b1; t_op = 5'd10; t_src1 = 32'd6; t_src2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept in_ready", in_ready, 1);
    check("flush_accept stall_req", stall_req, 0);
    count_pulses(3, pulses);
    check("flush_accept no_pulse", pulses, 0);

    // reset mid-multiply: outputs return to reset values
    in_valid = 1'b1; t_op = 5'd10; t_src1 = 32'd6; t_src2 = 32'd7; t_wd = 5'd5; t_wreg = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    count_pulses(40, pulses);
    check("mid_reset no_pulse", pulses, 0);
    run_op(5'd0, 32'd1, 32'd2, 5'd4, 1'b1, 32'd3, 1'b1, 1, "add_after_reset");

    // randomized ops against the model
    for (int k = 0; k < 80; k++) begin
      logic [4:0] rop;
      logic [31:0] ra, rb;
      int sel;
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      ra = $urandom; rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      model(rop, ra, rb, md, wok, mlat);
      run_op(rop, ra, rb, 5'($urandom), 1'b1, md, wok, mlat, $sformatf("rand%0d_op%0d", k, rop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
